// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU: decodes the ALU control code, detects
// load-use hazards (stall plus bubble), honours branch flush and counts stall bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [1:0]        id_alu_op_i,
  input  logic [5:0]        id_funct_i,
  input  logic              id_b_imm_i,
  input  logic              id_reg_dst_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_a_o,
  output logic [DATA_W-1:0] ex_b_o,
  output logic [2:0]        ex_alu_ctl_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic [REG_AW-1:0] ex_wr_reg_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_illegal_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {illegal, alu_ctl}; unknown R-type funct falls back to ADD and is flagged.
  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] res;
    res = {1'b0, CTL_ADD};
    case (op)
      2'b00: res = {1'b0, CTL_ADD};
      2'b01: res = {1'b0, CTL_SUB};
      2'b11: res = {1'b0, CTL_SLT};
      2'b10: begin
        case (funct)
          6'b100000: res = {1'b0, CTL_ADD};
          6'b100010: res = {1'b0, CTL_SUB};
          6'b100100: res = {1'b0, CTL_AND};
          6'b100101: res = {1'b0, CTL_OR};
          6'b101010: res = {1'b0, CTL_SLT};
          default:   res = {1'b1, CTL_ADD};
        endcase
      end
      default: res = {1'b0, CTL_ADD};
    endcase
    return res;
  endfunction

  logic              uses_rt;
  logic              rs_hit;
  logic              rt_hit;
  logic              hazard;
  logic              load;
  logic              cnt_inc;
  logic [3:0]        dec;

  logic              n_valid;
  logic [DATA_W-1:0] n_a;
  logic [DATA_W-1:0] n_b;
  logic [2:0]        n_ctl;
  logic [DATA_W-1:0] n_store;
  logic [REG_AW-1:0] n_wr;
  logic [REG_AW-1:0] n_rs;
  logic [REG_AW-1:0] n_rt;
  logic              n_mr;
  logic              n_mw;
  logic              n_rw;
  logic              n_m2r;
  logic              n_ill;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    uses_rt = ~id_b_imm_i | id_mem_write_i;
    rs_hit  = (ex_wr_reg_o == id_rs_i);
    rt_hit  = uses_rt & (ex_wr_reg_o == id_rt_i);
    hazard  = id_valid_i & ex_valid_o & ex_mem_read_o &
              (ex_wr_reg_o != {REG_AW{1'b0}}) & (rs_hit | rt_hit);
    load    = ~flush_i & ~hazard & id_valid_i;
    cnt_inc = ~flush_i & hazard & (stall_cnt_o != CNT_MAX);
  end

  assign stall_o = hazard;

  // Next EX contents: either the decoded ID instruction or a bubble.
  always_comb begin
    dec     = alu_decode(id_alu_op_i, id_funct_i);
    n_valid = 1'b0;
    n_a     = {DATA_W{1'b0}};
    n_b     = {DATA_W{1'b0}};
    n_ctl   = CTL_ADD;
    n_store = {DATA_W{1'b0}};
    n_wr    = {REG_AW{1'b0}};
    n_rs    = {REG_AW{1'b0}};
    n_rt    = {REG_AW{1'b0}};
    n_mr    = 1'b0;
    n_mw    = 1'b0;
    n_rw    = 1'b0;
    n_m2r   = 1'b0;
    n_ill   = 1'b0;
    if (load) begin
      n_valid = 1'b1;
      n_a     = id_rs_data_i;
      n_b     = id_b_imm_i ? id_imm_i : id_rt_data_i;
      n_ctl   = dec[2:0];
      n_store = id_rt_data_i;
      n_wr    = id_reg_dst_i ? id_rd_i : id_rt_i;
      n_rs    = id_rs_i;
      n_rt    = id_rt_i;
      n_mr    = id_mem_read_i;
      n_mw    = id_mem_write_i;
      n_rw    = id_reg_write_i;
      n_m2r   = id_mem_to_reg_i;
      n_ill   = dec[3];
    end else begin
      n_valid = 1'b0;
    end
  end

  // EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o      <= 1'b0;
      ex_a_o          <= {DATA_W{1'b0}};
      ex_b_o          <= {DATA_W{1'b0}};
      ex_alu_ctl_o    <= CTL_ADD;
      ex_store_data_o <= {DATA_W{1'b0}};
      ex_wr_reg_o     <= {REG_AW{1'b0}};
      ex_rs_o         <= {REG_AW{1'b0}};
      ex_rt_o         <= {REG_AW{1'b0}};
      ex_mem_read_o   <= 1'b0;
      ex_mem_write_o  <= 1'b0;
      ex_reg_write_o  <= 1'b0;
      ex_mem_to_reg_o <= 1'b0;
      ex_illegal_o    <= 1'b0;
    end else begin
      ex_valid_o      <= n_valid;
      ex_a_o          <= n_a;
      ex_b_o          <= n_b;
      ex_alu_ctl_o    <= n_ctl;
      ex_store_data_o <= n_store;
      ex_wr_reg_o     <= n_wr;
      ex_rs_o         <= n_rs;
      ex_rt_o         <= n_rt;
      ex_mem_read_o   <= n_mr;
      ex_mem_write_o  <= n_mw;
      ex_reg_write_o  <= n_rw;
      ex_mem_to_reg_o <= n_m2r;
      ex_illegal_o    <= n_ill;
    end
  end

  // Saturating bubble counter; a flushed stall does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= {CNT_W{1'b0}};
    end else if (cnt_inc) begin
      stall_cnt_o <= stall_cnt_o + CNT_ONE;
    end else begin
      stall_cnt_o <= stall_cnt_o;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// cycle-level reference model of the ID/EX register.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid, id_b_imm, id_reg_dst, id_mr, id_mw, id_rw, id_m2r, flush;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [1:0]        id_op;
  logic [5:0]        id_funct;

  logic              ex_valid, ex_mr, ex_mw, ex_rw, ex_m2r, ex_ill, stall;
  logic [DATA_W-1:0] ex_a, ex_b, ex_store;
  logic [2:0]        ex_ctl;
  logic [REG_AW-1:0] ex_wr, ex_rs, ex_rt;
  logic [CNT_W-1:0]  stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
    .id_imm_i(id_imm), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .id_alu_op_i(id_op), .id_funct_i(id_funct), .id_b_imm_i(id_b_imm),
    .id_reg_dst_i(id_reg_dst), .id_mem_read_i(id_mr), .id_mem_write_i(id_mw),
    .id_reg_write_i(id_rw), .id_mem_to_reg_i(id_m2r), .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_a_o(ex_a), .ex_b_o(ex_b), .ex_alu_ctl_o(ex_ctl),
    .ex_store_data_o(ex_store), .ex_wr_reg_o(ex_wr), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
    .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw), .ex_reg_write_o(ex_rw),
    .ex_mem_to_reg_o(ex_m2r), .ex_illegal_o(ex_ill), .stall_o(stall),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what EX should hold, plus the bubble count.
  bit              m_valid, m_mr, m_mw, m_rw, m_m2r, m_ill;
  logic [DATA_W-1:0] m_a, m_b, m_st;
  logic [2:0]      m_ctl;
  logic [REG_AW-1:0] m_wr, m_rs, m_rt;
  int              m_cnt;

  function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
    // {illegal, code}: AND=0, OR=1, ADD=2, SUB=6, SLT=7
    if (op == 2'd0) return {1'b0, 3'd2};
    if (op == 2'd1) return {1'b0, 3'd6};
    if (op == 2'd3) return {1'b0, 3'd7};
    if (f == 6'd32) return {1'b0, 3'd2};
    if (f == 6'd34) return {1'b0, 3'd6};
    if (f == 6'd36) return {1'b0, 3'd0};
    if (f == 6'd37) return {1'b0, 3'd1};
    if (f == 6'd42) return {1'b0, 3'd7};
    return {1'b1, 3'd2};
  endfunction

  function automatic bit ref_stall();
    bit reads_rs, reads_rt;
    if (!id_valid || !m_valid || !m_mr || m_wr == 0) return 1'b0;
    reads_rs = (m_wr == id_rs);
    reads_rt = (!id_b_imm || id_mw) && (m_wr == id_rt);
    return reads_rs || reads_rt;
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_ill = 0;
    m_a = 0; m_b = 0; m_st = 0; m_ctl = 3'd2; m_wr = 0; m_rs = 0; m_rt = 0;
  endtask

  task automatic model_step();
    bit s;
    logic [3:0] d;
    s = ref_stall();
    if (flush) begin
      model_bubble();
    end else if (s) begin
      model_bubble();
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (!id_valid) begin
      model_bubble();
    end else begin
      d = ref_alu(id_op, id_funct);
      m_valid = 1; m_a = id_rs_data; m_b = id_b_imm ? id_imm : id_rt_data;
      m_st = id_rt_data; m_ctl = d[2:0]; m_ill = d[3];
      m_wr = id_reg_dst ? id_rd : id_rt; m_rs = id_rs; m_rt = id_rt;
      m_mr = id_mr; m_mw = id_mw; m_rw = id_rw; m_m2r = id_m2r;
    end
  endtask

  function automatic logic [121:0] obs();
    return {ex_valid, ex_a, ex_b, ex_ctl, ex_store, ex_wr, ex_rs, ex_rt,
            ex_mr, ex_mw, ex_rw, ex_m2r, ex_ill, stall_cnt};
  endfunction

  function automatic logic [121:0] expv();
    logic [CNT_W-1:0] c;
    c = m_cnt[CNT_W-1:0];
    return {m_valid, m_a, m_b, m_ctl, m_st, m_wr, m_rs, m_rt,
            m_mr, m_mw, m_rw, m_m2r, m_ill, c};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input logic [1:0] op, input logic [5:0] f,
                        input int rs, input int rt, input int rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input bit bimm, input bit rdst, input bit mr, input bit mw,
                        input bit rw, input bit m2r);
    id_valid = v; id_op = op; id_funct = f;
    id_rs = rs[4:0]; id_rt = rt[4:0]; id_rd = rd[4:0];
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_b_imm = bimm; id_reg_dst = rdst; id_mr = mr; id_mw = mw; id_rw = rw; id_m2r = m2r;
  endtask

  task automatic set_lw(input int base, input int dst);
    set_id(1, 2'd0, 6'd0, base, dst, 0, $urandom, $urandom, $urandom, 1, 0, 1, 0, 1, 1);
  endtask

  task automatic set_add(input int rs, input int rt, input int rd);
    set_id(1, 2'd2, 6'd32, rs, rt, rd, $urandom, $urandom, $urandom, 0, 1, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_bubble();
    m_cnt = 0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_lw(1, 4);
    tick();
    set_add(4, 2, 9);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_prestall stall=%0b exp=1", stall); end
    #2;
    rst_n = 1'b0;
    model_bubble();
    m_cnt = 0;
    #1;
    n_cmp++;
    if (obs() !== expv()) begin n_bad++; $display("FAIL reset_async got=%h exp=%h", obs(), expv()); end
    n_cmp++;
    if (stall !== 1'b0 || ex_ctl !== 3'b010) begin
      n_bad++; $display("FAIL reset_stall stall=%0b ctl=%b exp 0/010", stall, ex_ctl);
    end
    set_id(0, 2'd0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype_sub();
    set_id(1, 2'b10, 6'b100010, 5, 3, 7, 32'd10, 32'd3, $urandom, 0, 1, 0, 0, 1, 0);
    tick();
    n_cmp++;
    if (ex_a !== 32'd10 || ex_b !== 32'd3 || ex_ctl !== 3'b110 || ex_wr !== 5'd7 || ex_rw !== 1'b1) begin
      n_bad++; $display("FAIL rtype_sub a=%0d b=%0d ctl=%b wr=%0d rw=%0b exp 10/3/110/7/1",
                        ex_a, ex_b, ex_ctl, ex_wr, ex_rw);
    end
    n_cmp++;
    if (obs() !== expv()) begin n_bad++; $display("FAIL rtype_sub_full got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_load_use();
    int c0;
    set_lw(1, 4);
    tick();
    set_add(4, 2, 9);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL load_use_stall stall=%0b exp=1", stall); end
    c0 = int'(stall_cnt);
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0 || int'(stall_cnt) != (c0 + 1) % (CNT_MAX + 1) || stall !== 1'b0) begin
      n_bad++; $display("FAIL load_use_bubble valid=%0b cnt=%0d stall=%0b exp 0/%0d/0",
                        ex_valid, stall_cnt, stall, c0 + 1);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_wr !== 5'd9 || obs() !== expv()) begin
      n_bad++; $display("FAIL load_use_reload got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_no_false_stall();
    set_lw(1, 0);
    tick();
    set_add(0, 0, 3);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL nostall_r0 stall=%0b exp=0", stall); end
    set_lw(1, 4);
    tick();
    set_id(1, 2'd0, 6'd0, 1, 4, 0, $urandom, $urandom, $urandom, 1, 0, 0, 0, 1, 0);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL nostall_addi stall=%0b exp=0", stall); end
    id_mw = 1'b1; id_rw = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL store_rt_stall stall=%0b exp=1", stall); end
    tick();
    tick();
    n_cmp++;
    if (obs() !== expv()) begin n_bad++; $display("FAIL store_after got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_flush_stall();
    int c0;
    set_lw(2, 6);
    tick();
    set_add(6, 6, 8);
    flush = 1'b1;
    c0 = int'(stall_cnt);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_stall_pre stall=%0b exp=1", stall); end
    tick();
    flush = 1'b0;
    n_cmp++;
    if (ex_valid !== 1'b0 || int'(stall_cnt) != c0 || obs() !== expv()) begin
      n_bad++; $display("FAIL flush_stall valid=%0b cnt=%0d exp 0/%0d", ex_valid, stall_cnt, c0);
    end
  endtask

  task automatic test_illegal();
    set_id(1, 2'b10, 6'b000111, 3, 2, 11, $urandom, $urandom, $urandom, 0, 1, 0, 0, 1, 0);
    tick();
    n_cmp++;
    if (ex_ill !== 1'b1 || ex_ctl !== 3'b010 || ex_rw !== 1'b1) begin
      n_bad++; $display("FAIL illegal ill=%0b ctl=%b rw=%0b exp 1/010/1", ex_ill, ex_ctl, ex_rw);
    end
    set_add(3, 2, 11);
    tick();
    n_cmp++;
    if (ex_ill !== 1'b0 || obs() !== expv()) begin
      n_bad++; $display("FAIL illegal_clear got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(posedge clk); #1;
    set_lw(4, 4);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL sat_step%0d got=%h exp=%h", i, obs(), expv()); end
    end
    n_cmp++;
    if (stall_cnt !== 2'd3) begin n_bad++; $display("FAIL saturation cnt=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_random();
    int bad_here;
    bad_here = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ref_stall() || ($urandom_range(0, 9) == 0)) begin
        set_id($urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(32 + 2 * $urandom_range(0, 5)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
               $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
        if (id_funct == 6'd42 + 6'd2) id_funct = 6'b100100;
      end
      flush = ($urandom_range(0, 11) == 0);
      #1;
      n_cmp++;
      if (stall !== ref_stall()) begin
        n_bad++; bad_here++;
        if (bad_here < 10) $display("FAIL rand_stall i=%0d got=%0b exp=%0b", i, stall, ref_stall());
      end
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; bad_here++;
        if (bad_here < 10) $display("FAIL rand_ex i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    flush = 1'b0;
    set_id(0, 2'd0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_bubble();
    m_cnt = 0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_rtype_sub();
    test_load_use();
    test_no_false_stall();
    test_flush_stall();
    test_illegal();
    test_saturation();
    do_reset();
    @(posedge clk); #1;
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
